wb_comp: RTL and testbench

//  Wishbone classic slave that compresses each access onto the narrow cw bus as its initiator.
//  The inverse of the decompressor: that block turns cw into Wishbone, this one turns Wishbone into cw.

---
 rtl/wb_comp_if.sv | 51 +++++
 rtl/wb_comp.sv | 185 ++++++++++++++++++
 tb/tb_wb_comp.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/wb_comp_if.sv
// wb_comp_if: bundles the two buses around the Wishbone-to-cw compressor.
//
// Parameters
//   RW      cw word / Wishbone data width
//   ADDR_W  Wishbone word-address width
//   SEL_W   Wishbone byte-select width
//
// Signals
//   wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_i_dat   Wishbone request from the master
//   wb_o_dat, wb_ack, wb_err                          Wishbone response to the master
//   cw_io_o, cw_req, cw_dir                           cw frame words to the responder
//   cw_io_i, cw_ack, cw_err                           cw response from the responder
//
// Modports
//   slave   the compressor itself (Wishbone slave, cw initiator)
//   master  everything around it: the Wishbone master together with the cw responder
interface wb_comp_if #(
  parameter int RW     = 16,
  parameter int ADDR_W = 24,
  parameter int SEL_W  = 2
);
  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_adr;
  logic [SEL_W-1:0]  wb_sel;
  logic [RW-1:0]     wb_i_dat;
  logic [RW-1:0]     wb_o_dat;
  logic              wb_ack;
  logic              wb_err;
  logic [RW-1:0]     cw_io_o;
  logic [RW-1:0]     cw_io_i;
  logic              cw_req;
  logic              cw_dir;
  logic              cw_ack;
  logic              cw_err;

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_i_dat,
    output wb_o_dat, wb_ack, wb_err,
    output cw_io_o, cw_req, cw_dir,
    input  cw_io_i, cw_ack, cw_err
  );

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_i_dat,
    input  wb_o_dat, wb_ack, wb_err,
    input  cw_io_o, cw_req, cw_dir,
    output cw_io_i, cw_ack, cw_err
  );
endinterface

// File: rtl/wb_comp.sv
// wb_comp: Wishbone classic slave that re-issues each access as a frame on the
// narrow cw bus, acting as the cw initiator. One transaction in flight; the
// Wishbone master is stalled (no ack) until the cw responder answers or the
// response timeout expires.
//
// Frame: ADR_LO (req=1) -> ADR_HI -> DATA (writes only), one word per cycle,
// then WAIT for cw_ack/cw_err, then a one-cycle wb_ack/wb_err pulse in RESP.
//
// Ports
//   i_clk   clock, rising edge
//   i_rst   asynchronous active-low reset
//   bus     wb_comp_if.slave: Wishbone slave side and cw initiator side
module wb_comp #(
  parameter int RW      = 16,
  parameter int ADDR_W  = 24,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 255
) (
  input logic        i_clk,
  input logic        i_rst,
  wb_comp_if.slave   bus
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADR_LO,
    ST_ADR_HI,
    ST_DATA,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic              we_q, we_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [RW-1:0]     dat_q, dat_d;
  logic              abort_q, abort_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]     cw_io_q, cw_io_d;
  logic              cw_req_q, cw_req_d;
  logic              cw_dir_q, cw_dir_d;
  logic              wb_ack_q, wb_ack_d;
  logic              wb_err_q, wb_err_d;
  logic [RW-1:0]     rdat_q, rdat_d;
  logic              resp_ok;
  logic              resp_bad;
  logic [RW-1:0]     hi_word;

  // Next state, request latch, timeout counter and Wishbone response.
  // A cw error beats a simultaneous cw ack; a real answer beats the timeout.
  // Once the master drops wb_cyc the frame still runs to completion, but the
  // abort flag swallows the resulting ack/err and leaves the read data alone.
  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    we_d     = we_q;
    sel_d    = sel_q;
    dat_d    = dat_q;
    abort_d  = abort_q;
    cnt_d    = '0;
    rdat_d   = rdat_q;
    resp_ok  = 1'b0;
    resp_bad = 1'b0;

    if (state_q != ST_IDLE && !bus.wb_cyc) begin
      abort_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.wb_cyc && bus.wb_stb) begin
          adr_d   = bus.wb_adr;
          we_d    = bus.wb_we;
          sel_d   = bus.wb_sel;
          dat_d   = bus.wb_i_dat;
          abort_d = 1'b0;
          state_d = ST_ADR_LO;
        end
      end
      ST_ADR_LO: state_d = ST_ADR_HI;
      ST_ADR_HI: state_d = we_q ? ST_DATA : ST_WAIT;
      ST_DATA:   state_d = ST_WAIT;
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.cw_err) begin
          resp_bad = 1'b1;
        end else if (bus.cw_ack) begin
          resp_ok = 1'b1;
        end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT)) begin
          resp_bad = 1'b1;
        end
        if (resp_ok || resp_bad) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    wb_ack_d = resp_ok && !abort_d;
    wb_err_d = resp_bad && !abort_d;
    if (resp_ok && !abort_d && !we_q) begin
      rdat_d = bus.cw_io_i;
    end
  end

  // cw outputs are decoded from the *next* state so that the registered word
  // appears in the cycle the FSM occupies that state (first word the cycle
  // after the request is taken).
  always_comb begin
    cw_io_d  = '0;
    cw_req_d = 1'b0;
    cw_dir_d = 1'b0;
    hi_word  = '0;
    hi_word[RW-1 -: SEL_W]  = sel_d;
    hi_word[ADDR_W-17:0]    = adr_d[ADDR_W-1:16];

    case (state_d)
      ST_ADR_LO: begin
        cw_io_d  = RW'(adr_d[15:0]);
        cw_req_d = 1'b1;
        cw_dir_d = we_d;
      end
      ST_ADR_HI: begin
        cw_io_d  = hi_word;
        cw_dir_d = we_d;
      end
      ST_DATA: begin
        cw_io_d  = dat_d;
        cw_dir_d = we_d;
      end
      ST_WAIT: begin
        cw_dir_d = we_d;
      end
      default: begin
        cw_io_d  = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= ST_IDLE;
      adr_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      dat_q    <= '0;
      abort_q  <= 1'b0;
      cnt_q    <= '0;
      cw_io_q  <= '0;
      cw_req_q <= 1'b0;
      cw_dir_q <= 1'b0;
      wb_ack_q <= 1'b0;
      wb_err_q <= 1'b0;
      rdat_q   <= '0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      dat_q    <= dat_d;
      abort_q  <= abort_d;
      cnt_q    <= cnt_d;
      cw_io_q  <= cw_io_d;
      cw_req_q <= cw_req_d;
      cw_dir_q <= cw_dir_d;
      wb_ack_q <= wb_ack_d;
      wb_err_q <= wb_err_d;
      rdat_q   <= rdat_d;
    end
  end

  assign bus.cw_io_o  = cw_io_q;
  assign bus.cw_req   = cw_req_q;
  assign bus.cw_dir   = cw_dir_q;
  assign bus.wb_ack   = wb_ack_q;
  assign bus.wb_err   = wb_err_q;
  assign bus.wb_o_dat = rdat_q;

endmodule

// File: tb/tb_wb_comp.sv
// tb_wb_comp: directed bench for wb_comp. Inputs change and outputs are
// sampled on the falling clock edge; "cN" comments count cycles from the
// cycle in which the request is presented (c0).
module tb_wb_comp;

  localparam int RW      = 16;
  localparam int ADDR_W  = 24;
  localparam int SEL_W   = 2;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  wb_comp_if #(.RW(RW), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) bus ();

  wb_comp #(
    .RW(RW), .ADDR_W(ADDR_W), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cw(input string tag, input logic [15:0] io, input logic req, input logic dir);
    check_output({tag, ".io"},  bus.cw_io_o, io);
    check_output({tag, ".req"}, bus.cw_req,  req);
    check_output({tag, ".dir"}, bus.cw_dir,  dir);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic we, input logic [23:0] adr,
                                input logic [1:0] sel, input logic [15:0] dat);
    bus.wb_cyc   = 1'b1;
    bus.wb_stb   = 1'b1;
    bus.wb_we    = we;
    bus.wb_adr   = adr;
    bus.wb_sel   = sel;
    bus.wb_i_dat = dat;
  endtask

  task automatic release_bus();
    bus.wb_cyc = 1'b0;
    bus.wb_stb = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b1;
    bus.wb_cyc   = 1'b0;
    bus.wb_stb   = 1'b0;
    bus.wb_we    = 1'b0;
    bus.wb_adr   = '0;
    bus.wb_sel   = '0;
    bus.wb_i_dat = '0;
    bus.cw_io_i  = '0;
    bus.cw_ack   = 1'b0;
    bus.cw_err   = 1'b0;
    #2 rst_n = 1'b0;
    step(2);
    check_cw("rst", 16'h0000, 1'b0, 1'b0);
    check_output("rst.ack",  bus.wb_ack,   0);
    check_output("rst.err",  bus.wb_err,   0);
    check_output("rst.odat", bus.wb_o_dat, 0);
    rst_n = 1'b1;
    step(1);

    // Write 0x123456 / sel 11 / 0xBEEF, responder acks in the second WAIT cycle
    $display("[TB] write");
    apply_stimulus(1'b1, 24'h123456, 2'b11, 16'hBEEF);
    step(1); check_cw("t1.adr_lo", 16'h3456, 1'b1, 1'b1);
    step(1); check_cw("t1.adr_hi", 16'hC012, 1'b0, 1'b1);
    step(1); check_cw("t1.data",   16'hBEEF, 1'b0, 1'b1);
    step(1); check_cw("t1.wait",   16'h0000, 1'b0, 1'b1);
    check_output("t1.ack_c4", bus.wb_ack, 0);
    step(1); check_output("t1.ack_c5", bus.wb_ack, 0);
    bus.cw_ack = 1'b1;
    step(1); bus.cw_ack = 1'b0;
    check_output("t1.ack_c6", bus.wb_ack, 1);
    check_output("t1.err_c6", bus.wb_err, 0);
    release_bus();
    step(1); check_output("t1.ack_c7", bus.wb_ack, 0);
    check_output("t1.dir_idle", bus.cw_dir, 0);

    // Read 0x000010 / sel 01, immediate ack with 0xA5A5 (minimum latency 4)
    $display("[TB] read");
    apply_stimulus(1'b0, 24'h000010, 2'b01, 16'h0000);
    step(1); check_cw("t2.adr_lo", 16'h0010, 1'b1, 1'b0);
    step(1); check_cw("t2.adr_hi", 16'h4000, 1'b0, 1'b0);
    step(1); check_cw("t2.wait",   16'h0000, 1'b0, 1'b0);
    bus.cw_ack = 1'b1; bus.cw_io_i = 16'hA5A5;
    step(1); bus.cw_ack = 1'b0; bus.cw_io_i = 16'h0000;
    check_output("t2.ack",  bus.wb_ack,   1);
    check_output("t2.odat", bus.wb_o_dat, 16'hA5A5);
    release_bus();
    step(1); check_output("t2.ack_off",  bus.wb_ack,   0);
    check_output("t2.odat_hold", bus.wb_o_dat, 16'hA5A5);

    // cw_ack and cw_err together: error wins, read data untouched
    $display("[TB] ack+err");
    apply_stimulus(1'b0, 24'h000020, 2'b11, 16'h0000);
    step(3);
    bus.cw_ack = 1'b1; bus.cw_err = 1'b1; bus.cw_io_i = 16'h1234;
    step(1); bus.cw_ack = 1'b0; bus.cw_err = 1'b0; bus.cw_io_i = 16'h0000;
    check_output("t3.err",  bus.wb_err,   1);
    check_output("t3.ack",  bus.wb_ack,   0);
    check_output("t3.odat", bus.wb_o_dat, 16'hA5A5);
    release_bus();
    step(1); check_output("t3.err_off", bus.wb_err, 0);

    // Silent responder: WAIT entered at c3, error pulse at c3+9
    $display("[TB] timeout");
    apply_stimulus(1'b0, 24'h000030, 2'b11, 16'h0000);
    step(3); check_cw("t4.wait", 16'h0000, 1'b0, 1'b0);
    step(8); check_output("t4.err_c11", bus.wb_err, 0);
    check_output("t4.ack_c11", bus.wb_ack, 0);
    step(1); check_output("t4.err_c12", bus.wb_err, 1);
    check_output("t4.ack_c12", bus.wb_ack, 0);
    release_bus();
    step(1); check_output("t4.err_c13", bus.wb_err, 0);
    check_output("t4.req_c13", bus.cw_req, 0);

    // wb_cyc dropped in ADR_HI: frame finishes, ack swallowed; a request
    // raised during RESP is only taken once back in IDLE
    $display("[TB] abort");
    apply_stimulus(1'b1, 24'h000100, 2'b10, 16'h5555);
    step(1); check_cw("t5.adr_lo", 16'h0100, 1'b1, 1'b1);
    step(1); check_cw("t5.adr_hi", 16'h8000, 1'b0, 1'b1);
    release_bus();
    step(1); check_cw("t5.data", 16'h5555, 1'b0, 1'b1);
    step(1); bus.cw_ack = 1'b1;
    step(1); bus.cw_ack = 1'b0;
    check_output("t5.ack_suppr", bus.wb_ack, 0);
    check_output("t5.err_suppr", bus.wb_err, 0);
    apply_stimulus(1'b0, 24'h000002, 2'b11, 16'h0000);
    step(1); check_output("t5.no_take_in_resp", bus.cw_req, 0);
    step(1); check_cw("t5b.adr_lo", 16'h0002, 1'b1, 1'b0);
    step(1); check_cw("t5b.adr_hi", 16'hC000, 1'b0, 1'b0);
    step(1); bus.cw_ack = 1'b1; bus.cw_io_i = 16'h0F0F;
    step(1); bus.cw_ack = 1'b0; bus.cw_io_i = 16'h0000;
    check_output("t5b.ack",  bus.wb_ack,   1);
    check_output("t5b.odat", bus.wb_o_dat, 16'h0F0F);
    release_bus();
    step(1);

    // Asynchronous reset in the middle of WAIT
    $display("[TB] reset mid-wait");
    apply_stimulus(1'b1, 24'hABCDEF, 2'b01, 16'h1111);
    step(1); check_cw("t6.adr_lo", 16'hCDEF, 1'b1, 1'b1);
    step(1); check_cw("t6.adr_hi", 16'h40AB, 1'b0, 1'b1);
    step(1); check_cw("t6.data",   16'h1111, 1'b0, 1'b1);
    step(1); check_output("t6.dir_wait", bus.cw_dir, 1);
    rst_n = 1'b0;
    release_bus();
    #1;
    check_cw("t6.rst", 16'h0000, 1'b0, 1'b0);
    check_output("t6.rst_ack",  bus.wb_ack,   0);
    check_output("t6.rst_err",  bus.wb_err,   0);
    check_output("t6.rst_odat", bus.wb_o_dat, 0);
    step(2); rst_n = 1'b1;
    step(1); bus.cw_ack = 1'b1;
    step(1); bus.cw_ack = 1'b0;
    check_output("t6.stale_ack", bus.wb_ack, 0);
    check_output("t6.stale_err", bus.wb_err, 0);
    check_output("t6.stale_req", bus.cw_req, 0);
    apply_stimulus(1'b0, 24'h000003, 2'b11, 16'h0000);
    step(1); check_cw("t6b.adr_lo", 16'h0003, 1'b1, 1'b0);
    step(1); check_cw("t6b.adr_hi", 16'hC000, 1'b0, 1'b0);
    step(1); bus.cw_ack = 1'b1; bus.cw_io_i = 16'h7E57;
    step(1); bus.cw_ack = 1'b0; bus.cw_io_i = 16'h0000;
    check_output("t6b.ack",  bus.wb_ack,   1);
    check_output("t6b.odat", bus.wb_o_dat, 16'h7E57);
    release_bus();
    step(1); check_output("t6b.ack_off", bus.wb_ack, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
